// File: rtl/apple_video_pkg.sv
// rtl/apple_video_pkg.sv - shared types, constants and row-address helper for text fetch
package apple_video_pkg;

  localparam logic [15:0] TEXT_BASE      = 16'h0400;
  localparam logic [15:0] TEXT_PAGE2_OFS = 16'h0400;
  localparam int          ROW_WORDS      = 20;
  localparam int          TEXT_ROWS      = 24;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_DONE
  } text_fetch_state_t;

  // Apple II text rows are interleaved: rows 0,8,16 share a 128-byte block.
  function automatic logic [15:0] text_row_base(input logic [4:0] row, input logic page2);
    logic [15:0] base;
    base = TEXT_BASE + (page2 ? TEXT_PAGE2_OFS : 16'h0000);
    base = base + {6'd0, row[2:0], 7'd0};
    base = base + (16'(row[4:3]) * 16'h0028);
    return base;
  endfunction

endpackage

// File: rtl/text_line_bank.sv
// rtl/text_line_bank.sv - two-bank 80-character line buffer, four byte-lane RAMs
module text_line_bank #(
  parameter logic [7:0] BLANK_CHAR = 8'hA0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic        wr_bank,
  input  logic [4:0]  wr_idx,
  input  logic [3:0]  wr_be,
  input  logic [31:0] wr_data,
  input  logic        rd_bank,
  input  logic [6:0]  rd_col,
  output logic [7:0]  rd_data
);

  logic [3:0][7:0] lane_rd;

  // Lane l holds columns 4*idx+l; address is {bank, column/4}.
  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] ram [0:63];

    always_ff @(posedge clk) begin
      if (wr_en && wr_be[l]) begin
        ram[{wr_bank, wr_idx}] <= wr_data[8*l +: 8];
      end
    end

    assign lane_rd[l] = ram[{rd_bank, rd_col[6:2]}];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= BLANK_CHAR;
    end else if (rd_col >= 7'd80) begin
      rd_data <= BLANK_CHAR;
    end else begin
      rd_data <= lane_rd[rd_col[1:0]];
    end
  end

endmodule

// File: rtl/apple_text_row_fetch.sv
// rtl/apple_text_row_fetch.sv - burst-fetches one text row from VRAM into a ping-pong line buffer
module apple_text_row_fetch #(
  parameter int         ROW_WORDS  = 20,
  parameter logic [7:0] BLANK_CHAR = 8'hA0
) (
  input  logic        clk_logic,
  input  logic        system_reset_n,
  input  logic        start_i,
  input  logic [4:0]  row_i,
  input  logic        page2_i,
  input  logic        col80_i,
  input  logic        swap_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] video_address_o,
  output logic        video_rd_o,
  input  logic [31:0] video_data_i,
  input  logic [6:0]  rd_col_i,
  output logic [7:0]  rd_char_o,
  output logic        front_col80_o
);

  import apple_video_pkg::*;

  text_fetch_state_t state, state_next;
  logic [4:0]  word_k;
  logic        front_sel;
  logic        back_col80;
  logic        wr_en;
  logic [4:0]  wr_k;
  logic        accept;
  logic [4:0]  wr_idx;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;

  assign accept = start_i && (state == ST_IDLE || state == ST_DONE) &&
                  (row_i < 5'(TEXT_ROWS));

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (accept) state_next = ST_FETCH;
      ST_FETCH: if (word_k == 5'(ROW_WORDS - 1)) state_next = ST_DRAIN;
      ST_DRAIN: state_next = ST_DONE;
      ST_DONE:  state_next = accept ? ST_FETCH : ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_logic or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state           <= ST_IDLE;
      word_k          <= 5'd0;
      video_address_o <= 16'h0000;
      back_col80      <= 1'b0;
      front_sel       <= 1'b0;
      front_col80_o   <= 1'b0;
      wr_en           <= 1'b0;
      wr_k            <= 5'd0;
    end else begin
      state <= state_next;
      wr_en <= (state == ST_FETCH);
      wr_k  <= word_k;
      if (accept) begin
        word_k          <= 5'd0;
        video_address_o <= text_row_base(row_i, page2_i);
        back_col80      <= col80_i;
      end else if (state == ST_FETCH) begin
        word_k          <= word_k + 5'd1;
        video_address_o <= video_address_o + 16'd2;
      end
      // Nonblocking order gives "swap first": front takes the old back's mode.
      if (swap_i) begin
        front_sel     <= ~front_sel;
        front_col80_o <= back_col80;
      end
    end
  end

  assign busy_o     = (state == ST_FETCH) || (state == ST_DRAIN);
  assign done_o     = (state == ST_DONE);
  assign video_rd_o = (state == ST_FETCH);

  always_comb begin
    wr_idx  = wr_k;
    wr_be   = 4'b0000;
    wr_data = 32'h0000_0000;
    if (back_col80) begin
      wr_be   = 4'b1111;
      wr_data = {video_data_i[23:16], video_data_i[31:24],
                 video_data_i[7:0], video_data_i[15:8]};
    end else begin
      // 40 columns: two main bytes per word, so a lane pair per word.
      wr_idx = {1'b0, wr_k[4:1]};
      if (wr_k[0]) begin
        wr_be   = 4'b1100;
        wr_data = {video_data_i[23:16], video_data_i[7:0], 16'h0000};
      end else begin
        wr_be   = 4'b0011;
        wr_data = {16'h0000, video_data_i[23:16], video_data_i[7:0]};
      end
    end
  end

  text_line_bank #(.BLANK_CHAR(BLANK_CHAR)) u_bank (
    .clk     (clk_logic),
    .rst_n   (system_reset_n),
    .wr_en   (wr_en),
    .wr_bank (~front_sel),
    .wr_idx  (wr_idx),
    .wr_be   (wr_be),
    .wr_data (wr_data),
    .rd_bank (front_sel),
    .rd_col  (rd_col_i),
    .rd_data (rd_char_o)
  );

endmodule

// File: tb/tb_apple_text_row_fetch.sv
// tb/tb_apple_text_row_fetch.sv - directed self-checking bench for apple_text_row_fetch
module tb_apple_text_row_fetch;

  logic        clk_logic = 1'b0;
  logic        system_reset_n;
  logic        start_i, page2_i, col80_i, swap_i;
  logic [4:0]  row_i;
  logic        busy_o, done_o, video_rd_o, front_col80_o;
  logic [15:0] video_address_o;
  logic [31:0] video_data_i;
  logic [6:0]  rd_col_i;
  logic [7:0]  rd_char_o;

  int n_cmp  = 0;
  int n_fail = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  logic [15:0] cur_base = 16'h0000;
  logic [7:0]  seed = 8'h00;

  typedef struct {
    logic [6:0] col;
    logic [7:0] exp;
  } rd_vec_t;

  rd_vec_t tbl [0:7];

  always #5 clk_logic = ~clk_logic;

  apple_text_row_fetch dut (
    .clk_logic       (clk_logic),
    .system_reset_n  (system_reset_n),
    .start_i         (start_i),
    .row_i           (row_i),
    .page2_i         (page2_i),
    .col80_i         (col80_i),
    .swap_i          (swap_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .video_address_o (video_address_o),
    .video_rd_o      (video_rd_o),
    .video_data_i    (video_data_i),
    .rd_col_i        (rd_col_i),
    .rd_char_o       (rd_char_o),
    .front_col80_o   (front_col80_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // VRAM model: word k of the current row holds bytes {b+3,b+2,b+1,b}, b = k + seed.
  always @(posedge clk_logic) begin
    logic [7:0] b;
    b = 8'((video_address_o - cur_base) >> 1) + seed;
    video_data_i <= video_rd_o ? {b + 8'd3, b + 8'd2, b + 8'd1, b} : 32'h0;
  end

  always @(negedge clk_logic) begin
    if (video_rd_o === 1'b1) begin
      chk("addr", {16'h0, video_address_o}, {16'h0, cur_base + 16'(2 * rd_cnt)});
      rd_cnt++;
    end
    if (done_o === 1'b1) done_cnt++;
  end

  task automatic run_fetch(input logic [4:0] row, input logic pg, input logic c80,
                           input logic [15:0] base, input logic [7:0] sd,
                           input logic do_swap, input int ignore_at, input int front_exp);
    int first_done;
    first_done = -1;
    cur_base = base;
    seed = sd;
    rd_cnt = 0;
    done_cnt = 0;
    @(negedge clk_logic);
    row_i = row; page2_i = pg; col80_i = c80; start_i = 1'b1; swap_i = do_swap;
    @(posedge clk_logic);
    #1 start_i = 1'b0; swap_i = 1'b0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk_logic);
      start_i = (cyc == ignore_at);
      if (done_o === 1'b1 && first_done < 0) first_done = cyc;
      if (cyc == 1)  chk("busy_t1", {31'd0, busy_o}, 32'd1);
      if (cyc == 21) chk("busy_drain", {31'd0, busy_o}, 32'd1);
      if (cyc == 22) begin
        chk("busy_t22", {31'd0, busy_o}, 32'd0);
        chk("done_t22", {31'd0, done_o}, 32'd1);
      end
      if (front_exp >= 0 && cyc >= 2) chk("front_stable", {24'd0, rd_char_o}, 32'(front_exp));
    end
    start_i = 1'b0;
    chk("done_cycle", 32'(first_done), 32'd22);
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("read_count", 32'(rd_cnt), 32'd20);
  endtask

  task automatic pulse_swap();
    @(negedge clk_logic);
    swap_i = 1'b1;
    @(posedge clk_logic);
    #1 swap_i = 1'b0;
  endtask

  task automatic rd(input logic [6:0] col, input logic [7:0] exp, input string name);
    @(negedge clk_logic);
    rd_col_i = col;
    @(posedge clk_logic);
    #1 chk(name, {24'd0, rd_char_o}, {24'd0, exp});
  endtask

  initial begin
    tbl[0] = '{7'd0,   8'h00};
    tbl[1] = '{7'd1,   8'h02};
    tbl[2] = '{7'd2,   8'h01};
    tbl[3] = '{7'd3,   8'h03};
    tbl[4] = '{7'd38,  8'h13};
    tbl[5] = '{7'd39,  8'h15};
    tbl[6] = '{7'd85,  8'hA0};
    tbl[7] = '{7'd127, 8'hA0};

    system_reset_n = 1'b0;
    start_i = 1'b0; swap_i = 1'b0; page2_i = 1'b0; col80_i = 1'b0;
    row_i = 5'd0; rd_col_i = 7'd0;
    repeat (3) @(posedge clk_logic);
    #1;
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_rd", {31'd0, video_rd_o}, 32'd0);
    chk("rst_addr", {16'd0, video_address_o}, 32'd0);
    chk("rst_fc80", {31'd0, front_col80_o}, 32'd0);
    chk("rst_char", {24'd0, rd_char_o}, 32'h0000_00A0);
    @(negedge clk_logic);
    system_reset_n = 1'b1;

    // Row 0, page 1, 40 columns into bank 1, then show it.
    run_fetch(5'd0, 1'b0, 1'b0, 16'h0400, 8'h00, 1'b0, 0, -1);
    pulse_swap();
    #1 chk("fc80_row0", {31'd0, front_col80_o}, 32'd0);
    for (int i = 0; i < 8; i++) rd(tbl[i].col, tbl[i].exp, $sformatf("row0_col%0d", tbl[i].col));

    // Row 13, page 2, 80 columns into bank 0 while row 0 stays on the front.
    rd_col_i = 7'd1;
    run_fetch(5'd13, 1'b1, 1'b1, 16'h0AA8, 8'h40, 1'b0, 0, 8'h02);

    // Row 24 is out of range: nothing happens.
    rd_cnt = 0; done_cnt = 0;
    @(negedge clk_logic);
    row_i = 5'd24; start_i = 1'b1;
    @(posedge clk_logic);
    #1 start_i = 1'b0;
    repeat (30) @(negedge clk_logic);
    chk("row24_reads", 32'(rd_cnt), 32'd0);
    chk("row24_done", 32'(done_cnt), 32'd0);
    chk("row24_busy", {31'd0, busy_o}, 32'd0);

    // Swap and start together, with a second start ignored mid-fetch.
    rd_col_i = 7'd0;
    run_fetch(5'd5, 1'b0, 1'b0, 16'h0680, 8'h80, 1'b1, 5, 8'h41);
    chk("fc80_row13", {31'd0, front_col80_o}, 32'd1);
    rd(7'd4,  8'h42, "row13_col4");
    rd(7'd6,  8'h44, "row13_col6");
    rd(7'd79, 8'h55, "row13_col79");
    rd(7'd85, 8'hA0, "row13_col85");
    pulse_swap();
    #1 chk("fc80_row5", {31'd0, front_col80_o}, 32'd0);
    rd(7'd0,  8'h80, "row5_col0");
    rd(7'd1,  8'h82, "row5_col1");
    rd(7'd39, 8'h95, "row5_col39");

    // Reset in the middle of a fetch.
    cur_base = 16'h0500; seed = 8'h00; rd_cnt = 0; done_cnt = 0;
    @(negedge clk_logic);
    row_i = 5'd2; page2_i = 1'b0; col80_i = 1'b0; start_i = 1'b1;
    @(posedge clk_logic);
    #1 start_i = 1'b0;
    repeat (10) @(negedge clk_logic);
    #2 system_reset_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy_o}, 32'd0);
    chk("arst_rd", {31'd0, video_rd_o}, 32'd0);
    chk("arst_addr", {16'd0, video_address_o}, 32'd0);
    chk("arst_fc80", {31'd0, front_col80_o}, 32'd0);
    chk("arst_char", {24'd0, rd_char_o}, 32'h0000_00A0);
    chk("arst_reads", 32'(rd_cnt), 32'd10);
    repeat (2) @(posedge clk_logic);
    @(negedge clk_logic);
    system_reset_n = 1'b1;
    repeat (30) @(negedge clk_logic);
    chk("arst_no_done", 32'(done_cnt), 32'd0);

    // Normal fetch after reset: row 23, 80 columns, lands in bank 1.
    run_fetch(5'd23, 1'b0, 1'b1, 16'h07D0, 8'hC0, 1'b0, 0, -1);
    pulse_swap();
    #1 chk("fc80_row23", {31'd0, front_col80_o}, 32'd1);
    rd(7'd2,  8'hC3, "row23_col2");
    rd(7'd77, 8'hD3, "row23_col77");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
